// File: rtl/fetch_instruction.sv
// fetch_instruction
//   Instruction-fetch stage feeding decode_instruction. Owns the fetch PC and
//   issues word addresses to a synchronous instruction memory with one cycle
//   of read latency. Returned words land in a two-entry buffer (output register
//   plus skid register), so a decode stall never drops or repeats an
//   instruction. A branch redirect flushes everything and restarts at the target.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   stall_i      decode stall; output register holds while high
//   br_taken_i   redirect request (1-cycle pulse)
//   br_addr_i    redirect target
//   imem_req_o   instruction-memory read request this cycle
//   imem_addr_o  read address (always the fetch PC)
//   imem_data_i  read data, valid the cycle after the request
//   inst_o       instruction to decode
//   pc_o         PC of inst_o
//   v_o          inst_o / pc_o valid
module fetch_instruction #(
  parameter int              WORD     = 32,
  parameter int              ADDR     = 32,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [ADDR-1:0] br_addr_i,
  output logic            imem_req_o,
  output logic [ADDR-1:0] imem_addr_o,
  input  logic [WORD-1:0] imem_data_i,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] pc_o,
  output logic            v_o
);

  logic [ADDR-1:0] fpc_q, fpc_d;
  logic            req_v_q, req_v_d;
  logic [ADDR-1:0] req_pc_q, req_pc_d;
  logic            out_v_q, out_v_d;
  logic [WORD-1:0] out_inst_q, out_inst_d;
  logic [ADDR-1:0] out_pc_q, out_pc_d;
  logic            sk_v_q, sk_v_d;
  logic [WORD-1:0] sk_inst_q, sk_inst_d;
  logic [ADDR-1:0] sk_pc_q, sk_pc_d;

  logic [1:0] occ;
  logic       issue;
  logic       load_ok;

  // Occupancy counts every slot that holds or will hold an instruction. A new
  // request is only allowed when it can never overflow the skid, even if the
  // stall stays asserted.
  always_comb begin
    occ     = {1'b0, out_v_q} + {1'b0, sk_v_q} + {1'b0, req_v_q};
    issue   = ~reset & ~br_taken_i & (({1'b0, occ} + {2'b00, stall_i}) <= 3'd2);
    load_ok = ~stall_i | ~out_v_q;
  end

  always_comb begin
    fpc_d      = fpc_q;
    req_v_d    = issue;
    req_pc_d   = req_pc_q;
    out_v_d    = out_v_q;
    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
    sk_v_d     = sk_v_q;
    sk_inst_d  = sk_inst_q;
    sk_pc_d    = sk_pc_q;

    if (issue) begin
      req_pc_d = fpc_q;
      fpc_d    = fpc_q + ADDR'(1);
    end

    if (load_ok) begin
      if (sk_v_q) begin
        // Skid is older than the response, so it drains first.
        out_v_d    = 1'b1;
        out_inst_d = sk_inst_q;
        out_pc_d   = sk_pc_q;
        if (req_v_q) begin
          sk_inst_d = imem_data_i;
          sk_pc_d   = req_pc_q;
        end else begin
          sk_v_d = 1'b0;
        end
      end else if (req_v_q) begin
        out_v_d    = 1'b1;
        out_inst_d = imem_data_i;
        out_pc_d   = req_pc_q;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (req_v_q) begin
      sk_v_d    = 1'b1;
      sk_inst_d = imem_data_i;
      sk_pc_d   = req_pc_q;
    end

    // Redirect discards the buffer and the response arriving this cycle.
    if (br_taken_i) begin
      out_v_d = 1'b0;
      sk_v_d  = 1'b0;
      req_v_d = 1'b0;
      fpc_d   = br_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      req_v_q    <= 1'b0;
      req_pc_q   <= '0;
      out_v_q    <= 1'b0;
      out_inst_q <= '0;
      out_pc_q   <= '0;
      sk_v_q     <= 1'b0;
      sk_inst_q  <= '0;
      sk_pc_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      req_v_q    <= req_v_d;
      req_pc_q   <= req_pc_d;
      out_v_q    <= out_v_d;
      out_inst_q <= out_inst_d;
      out_pc_q   <= out_pc_d;
      sk_v_q     <= sk_v_d;
      sk_inst_q  <= sk_inst_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = fpc_q;
  assign inst_o      = out_inst_q;
  assign pc_o        = out_pc_q;
  assign v_o         = out_v_q;

endmodule

// File: tb/tb_fetch_instruction.sv
module tb_fetch_instruction;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: RESET_PC = 0x10
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        v;

  // Instance 2: RESET_PC = 2^32-2, free-running
  logic        reset2 = 1'b1;
  logic        stall2 = 1'b0;
  logic        br_taken2 = 1'b0;
  logic [31:0] br_addr2 = '0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_data2 = '0;
  logic [31:0] inst2;
  logic [31:0] pc2;
  logic        v2;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_instruction #(.WORD(32), .ADDR(32), .RESET_PC(32'h0000_0010)) dut (
    .clk(clk), .reset(reset), .stall_i(stall), .br_taken_i(br_taken),
    .br_addr_i(br_addr), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_data_i(imem_data), .inst_o(inst), .pc_o(pc), .v_o(v)
  );

  fetch_instruction #(.WORD(32), .ADDR(32), .RESET_PC(32'hFFFF_FFFE)) dut2 (
    .clk(clk), .reset(reset2), .stall_i(stall2), .br_taken_i(br_taken2),
    .br_addr_i(br_addr2), .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
    .imem_data_i(imem_data2), .inst_o(inst2), .pc_o(pc2), .v_o(v2)
  );

  // Synchronous instruction memories: inst = 0xA000_0000 | addr, garbage when idle.
  always @(posedge clk) begin
    imem_data  <= imem_req  ? (32'hA000_0000 | imem_addr)  : 32'hDEAD_BEEF;
    imem_data2 <= imem_req2 ? (32'hA000_0000 | imem_addr2) : 32'hDEAD_BEEF;
  end

  // Buffer must never overflow and the skid is only occupied behind a valid output.
  always @(negedge clk) begin
    n_assert++;
    assert ((dut.occ <= 2'd2) && (!dut.sk_v_q || dut.out_v_q)) else begin
      n_fail++;
      $display("FAIL occupancy: observed occ=%0d sk_v=%0b out_v=%0b required occ<=2 and sk_v->out_v",
               dut.occ, dut.sk_v_q, dut.out_v_q);
      $error("occupancy check");
    end
    n_assert++;
    assert ((dut2.occ <= 2'd2) && (!dut2.sk_v_q || dut2.out_v_q)) else begin
      n_fail++;
      $display("FAIL occupancy2: observed occ=%0d sk_v=%0b out_v=%0b required occ<=2 and sk_v->out_v",
               dut2.occ, dut2.sk_v_q, dut2.out_v_q);
      $error("occupancy2 check");
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one cycle: drive inputs 1 ns after the edge, sample 1 ns later.
  task automatic cyc(input logic r, input logic r2, input logic s, input logic b,
                     input logic [31:0] ba);
    @(posedge clk);
    #1;
    reset    = r;
    reset2   = r2;
    stall    = s;
    br_taken = b;
    br_addr  = ba;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp_pc);
    chk({tag, ".v"},    64'(v),    64'd1);
    chk({tag, ".pc"},   64'(pc),   64'(exp_pc));
    chk({tag, ".inst"}, 64'(inst), 64'(32'hA000_0000 | exp_pc));
  endtask

  task automatic chk_out2(input string tag, input logic [31:0] exp_pc);
    chk({tag, ".v2"},    64'(v2),    64'd1);
    chk({tag, ".pc2"},   64'(pc2),   64'(exp_pc));
    chk({tag, ".inst2"}, 64'(inst2), 64'(32'hA000_0000 | exp_pc));
  endtask

  initial begin
    // Reset state
    repeat (3) cyc(1, 1, 0, 0, 32'h0);
    chk("rst.v",    64'(v),         64'd0);
    chk("rst.inst", 64'(inst),      64'd0);
    chk("rst.pc",   64'(pc),        64'd0);
    chk("rst.req",  64'(imem_req),  64'd0);
    chk("rst.addr", 64'(imem_addr), 64'h10);

    // Free-run from 0x10
    cyc(0, 1, 0, 0, 32'h0);                          // cycle 0
    chk("c0.req",  64'(imem_req),  64'd1);
    chk("c0.addr", 64'(imem_addr), 64'h10);
    chk("c0.v",    64'(v),         64'd0);
    cyc(0, 1, 0, 0, 32'h0);                          // cycle 1
    chk("c1.v",    64'(v),         64'd0);
    chk("c1.addr", 64'(imem_addr), 64'h11);
    for (int i = 0; i < 4; i++) begin                // cycles 2..5
      cyc(0, 1, 0, 0, 32'h0);
      chk_out("run", 32'h10 + 32'(i));
    end

    // Stall 5 cycles while pc_o = 0x14
    for (int i = 0; i < 5; i++) begin                // cycles 6..10
      cyc(0, 1, 1, 0, 32'h0);
      chk_out("stall", 32'h14);
      chk("stall.req", 64'(imem_req), 64'd0);
    end
    cyc(0, 1, 0, 0, 32'h0);                          // cycle 11: release
    chk_out("rel0", 32'h14);
    chk("rel0.req",  64'(imem_req),  64'd1);
    chk("rel0.addr", 64'(imem_addr), 64'h16);
    for (int i = 0; i < 4; i++) begin                // cycles 12..15
      cyc(0, 1, 0, 0, 32'h0);
      chk_out("rel", 32'h15 + 32'(i));
    end

    // Redirect to 0x200 during streaming
    cyc(0, 1, 0, 1, 32'h200);                        // cycle r
    chk_out("br", 32'h19);
    chk("br.req", 64'(imem_req), 64'd0);
    cyc(0, 1, 0, 0, 32'h0);                          // r+1
    chk("br1.v",    64'(v),         64'd0);
    chk("br1.req",  64'(imem_req),  64'd1);
    chk("br1.addr", 64'(imem_addr), 64'h200);
    cyc(0, 1, 0, 0, 32'h0);                          // r+2
    chk("br2.v", 64'(v), 64'd0);
    cyc(0, 1, 0, 0, 32'h0);                          // r+3
    chk_out("br3", 32'h200);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("br4", 32'h201);

    // Fill the skid under stall, then redirect to 0x40 while still stalled
    cyc(0, 1, 1, 0, 32'h0);
    chk_out("sbr0", 32'h202);
    cyc(0, 1, 1, 0, 32'h0);
    chk_out("sbr1", 32'h202);
    chk("sbr1.skid", 64'(dut.sk_v_q), 64'd1);
    cyc(0, 1, 1, 1, 32'h40);
    chk_out("sbr2", 32'h202);
    chk("sbr2.req", 64'(imem_req), 64'd0);
    cyc(0, 1, 0, 0, 32'h0);
    chk("sbr3.v",    64'(v),         64'd0);
    chk("sbr3.req",  64'(imem_req),  64'd1);
    chk("sbr3.addr", 64'(imem_addr), 64'h40);
    cyc(0, 1, 0, 0, 32'h0);
    chk("sbr4.v", 64'(v), 64'd0);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("sbr5", 32'h40);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("sbr6", 32'h41);

    // Reset mid-stream, then stall held through startup
    cyc(1, 1, 1, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h0);
    chk("srst.v",  64'(v),  64'd0);
    chk("srst.pc", 64'(pc), 64'd0);
    cyc(0, 1, 1, 0, 32'h0);                          // cycle 0
    chk("st0.req",  64'(imem_req),  64'd1);
    chk("st0.addr", 64'(imem_addr), 64'h10);
    cyc(0, 1, 1, 0, 32'h0);                          // cycle 1
    chk("st1.v",   64'(v),        64'd0);
    chk("st1.req", 64'(imem_req), 64'd1);
    cyc(0, 1, 1, 0, 32'h0);                          // cycle 2
    chk_out("st2", 32'h10);
    chk("st2.req", 64'(imem_req), 64'd0);
    cyc(0, 1, 1, 0, 32'h0);                          // cycle 3
    chk_out("st3", 32'h10);
    cyc(0, 1, 0, 0, 32'h0);                          // cycle 4: release
    chk_out("st4", 32'h10);
    chk("st4.addr", 64'(imem_addr), 64'h12);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("st5", 32'h11);
    cyc(0, 1, 0, 0, 32'h0);
    chk_out("st6", 32'h12);

    // Instance 2: PC wrap from 2^32-2
    chk("w.rst.v",    64'(v2),         64'd0);
    chk("w.rst.pc",   64'(pc2),        64'd0);
    chk("w.rst.inst", 64'(inst2),      64'd0);
    chk("w.rst.req",  64'(imem_req2),  64'd0);
    chk("w.rst.addr", 64'(imem_addr2), 64'hFFFF_FFFE);
    cyc(0, 0, 0, 0, 32'h0);                          // cycle 0
    chk("w0.req",  64'(imem_req2),  64'd1);
    chk("w0.addr", 64'(imem_addr2), 64'hFFFF_FFFE);
    cyc(0, 0, 0, 0, 32'h0);                          // cycle 1
    chk("w1.addr", 64'(imem_addr2), 64'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 32'h0);                          // cycle 2
    chk_out2("w2", 32'hFFFF_FFFE);
    chk("w2.addr", 64'(imem_addr2), 64'h0);
    cyc(0, 0, 0, 0, 32'h0);
    chk_out2("w3", 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 32'h0);
    chk_out2("w4", 32'h0000_0000);
    cyc(0, 0, 0, 0, 32'h0);
    chk_out2("w5", 32'h0000_0001);
    cyc(0, 1, 0, 0, 32'h0);                          // 1-cycle reset
    chk("wr.req", 64'(imem_req2), 64'd0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("wr1.v",    64'(v2),         64'd0);
    chk("wr1.pc",   64'(pc2),        64'd0);
    chk("wr1.inst", 64'(inst2),      64'd0);
    chk("wr1.req",  64'(imem_req2),  64'd1);
    chk("wr1.addr", 64'(imem_addr2), 64'hFFFF_FFFE);
    cyc(0, 0, 0, 0, 32'h0);
    chk("wr2.v", 64'(v2), 64'd0);
    cyc(0, 0, 0, 0, 32'h0);
    chk_out2("wr3", 32'hFFFF_FFFE);
    cyc(0, 0, 0, 0, 32'h0);
    chk_out2("wr4", 32'hFFFF_FFFF);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
